// File: rtl/pmem_burst_ctrl_pkg.sv
// Shared cache package: line geometry, burst FSM state type and line-address helper.
package pmem_burst_ctrl_pkg;

  localparam int unsigned LINE_BYTES     = 32;
  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned BEATS_PER_LINE = LINE_BYTES / WORD_BYTES;
  localparam int unsigned LINE_OFF_W     = $clog2(LINE_BYTES);

  typedef enum logic [1:0] {
    StIdle,
    StRdBurst,
    StWrBurst,
    StDone
  } burst_state_t;

  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/burst_watchdog.sv
// Per-beat stall watchdog: fires in the TIMEOUT_CYCLES-th consecutive stalled cycle.
// Only instantiated when BURST_TIMEOUT_EN is defined.
module burst_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;
  logic            stall;

  assign stall    = active_i && !ready_i;
  assign expire_o = stall && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !stall || expire_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pmem_burst_ctrl.sv
// Cache-line burst controller: splits a 256-bit line fill / write-back into word beats.
// Optional per-beat stall watchdog enabled by defining BURST_TIMEOUT_EN.
module pmem_burst_ctrl
  import pmem_burst_ctrl_pkg::*;
#(
  parameter int unsigned BEATS          = BEATS_PER_LINE,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_read,
  input  logic        line_write,
  input  logic [31:0] line_addr,
  input  logic [31:0] wr_beat,
  output logic        wr_beat_req,
  output logic [31:0] rd_beat,
  output logic        rd_beat_valid,
  output logic        line_resp,
  output logic        line_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned    BeatW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

  burst_state_t     state_q;
  logic [BeatW-1:0] beat_q;
  logic [31:0]      base_q;
  logic [31:0]      rd_beat_q;
  logic             rd_beat_valid_q;
  logic             in_burst;
  logic             timeout;

  assign in_burst = (state_q == StRdBurst) || (state_q == StWrBurst);

`ifdef BURST_TIMEOUT_EN
  burst_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .active_i (in_burst),
    .ready_i  (mem_ready),
    .expire_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      beat_q          <= '0;
      base_q          <= '0;
      rd_beat_q       <= '0;
      rd_beat_valid_q <= 1'b0;
    end else begin
      rd_beat_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Write-back wins so a dirty victim leaves before its refill arrives.
          if (line_write) begin
            state_q <= StWrBurst;
            base_q  <= line_base(line_addr);
            beat_q  <= '0;
          end else if (line_read) begin
            state_q <= StRdBurst;
            base_q  <= line_base(line_addr);
            beat_q  <= '0;
          end
        end
        StRdBurst: begin
          if (timeout) begin
            state_q <= StIdle;
            beat_q  <= '0;
          end else if (mem_ready) begin
            rd_beat_q       <= mem_rdata;
            rd_beat_valid_q <= 1'b1;
            if (beat_q == LastBeat) begin
              beat_q  <= '0;
              state_q <= StDone;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StWrBurst: begin
          if (timeout) begin
            state_q <= StIdle;
            beat_q  <= '0;
          end else if (mem_ready) begin
            if (beat_q == LastBeat) begin
              beat_q  <= '0;
              state_q <= StDone;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_rd        = (state_q == StRdBurst);
  assign mem_wr        = (state_q == StWrBurst);
  assign mem_addr      = in_burst ? (base_q + (32'(beat_q) * 32'(WORD_BYTES))) : '0;
  assign mem_wdata     = mem_wr ? wr_beat : '0;
  assign wr_beat_req   = mem_wr && mem_ready;
  assign rd_beat       = rd_beat_q;
  assign rd_beat_valid = rd_beat_valid_q;
  assign line_resp     = (state_q == StDone) || timeout;
  assign line_err      = timeout;

endmodule
